// File: rtl/ramp_sequencer_pkg.sv
// Shared types and constants for the ramp sequencer.
//   state_t  : sequencer FSM state (idle / ramping)
//   DIR_UP   : direction flag value for an incrementing ramp
//   DIR_DOWN : direction flag value for a decrementing ramp
package ramp_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/ramp_prescaler.sv
// Loadable down-counter that paces ramp steps.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset (counter clears to 0)
//   load      : load load_val on the next edge (wins over en)
//   en        : decrement on the next edge; saturates at zero
//   load_val  : reload value (step period minus one)
//   zero      : counter currently equals zero, a step is due
module ramp_prescaler #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] load_val,
   output logic                 zero
);

   logic [DIV_WIDTH-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - DIV_WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ramp_sequencer.sv
// Ramps a position count one LSB at a time toward a commanded target at a
// programmable step rate, then reports completion. One command at a time.
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   cmd_valid_i  : command valid
//   cmd_ready_o  : command ready (high exactly when idle)
//   cmd_target_i : target count, sampled on accept
//   cmd_div_i    : step period minus one, sampled on accept
//   abort_i      : cancel the ramp in progress (ignored when idle)
//   count_o      : current position
//   step_o       : pulse, count_o changed on the previous edge
//   up_o         : direction of the last step (1 = increment)
//   busy_o       : ramp in progress
//   done_o       : pulse, count_o reached the target
//   aborted_o    : pulse, ramp cancelled by abort_i
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a command; cmd_ready_o high
// ST_RAMP | stepping count_o toward target_q every div_q+1 edges
module ramp_sequencer
   import ramp_sequencer_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int unsigned INIT      = 0,
   parameter int          DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [WIDTH-1:0]     cmd_target_i,
   input  logic [DIV_WIDTH-1:0] cmd_div_i,
   input  logic                 abort_i,
   output logic [WIDTH-1:0]     count_o,
   output logic                 step_o,
   output logic                 up_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 aborted_o
);

   if ((INIT >> WIDTH) != 0) begin : g_init_check
      $error("ramp_sequencer: INIT does not fit in WIDTH bits");
   end

   localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

   state_t               state;
   logic [WIDTH-1:0]     target_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [WIDTH-1:0]     next_count;
   logic                 accept;
   logic                 step_due;
   logic                 pre_load;
   logic                 pre_en;
   logic [DIV_WIDTH-1:0] pre_val;
   logic                 pre_zero;

   assign cmd_ready_o = (state == ST_IDLE);
   assign accept      = cmd_ready_o && cmd_valid_i;
   // abort outranks a due step, so a step only happens when abort is low
   assign step_due    = (state == ST_RAMP) && !abort_i && pre_zero;
   assign next_count  = (up_o == DIR_UP) ? count_o + WIDTH'(1) : count_o - WIDTH'(1);

   // Prescaler: loaded with the new divider on accept, reloaded after each
   // step, counts down otherwise while ramping; frozen on abort.
   assign pre_load = accept || step_due;
   assign pre_val  = accept ? cmd_div_i : div_q;
   assign pre_en   = (state == ST_RAMP) && !abort_i && !pre_zero;

   ramp_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (pre_load),
      .en       (pre_en),
      .load_val (pre_val),
      .zero     (pre_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         target_q  <= '0;
         div_q     <= '0;
         count_o   <= INIT_VAL;
         step_o    <= 1'b0;
         up_o      <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         aborted_o <= 1'b0;
      end else begin
         step_o    <= 1'b0;
         done_o    <= 1'b0;
         aborted_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  target_q <= cmd_target_i;
                  div_q    <= cmd_div_i;
                  if (cmd_target_i == count_o) begin
                     // already there: complete without stepping
                     done_o <= 1'b1;
                  end else begin
                     state  <= ST_RAMP;
                     busy_o <= 1'b1;
                     up_o   <= (cmd_target_i > count_o) ? DIR_UP : DIR_DOWN;
                  end
               end
            end
            ST_RAMP: begin
               if (abort_i) begin
                  state     <= ST_IDLE;
                  busy_o    <= 1'b0;
                  aborted_o <= 1'b1;
               end else if (step_due) begin
                  count_o <= next_count;
                  step_o  <= 1'b1;
                  if (next_count == target_q) begin
                     state  <= ST_IDLE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Self-checking bench for ramp_sequencer: directed scenarios followed by
// random commands, compared cycle by cycle against a transaction-level model
// (step count = elapsed edges / step period, clipped at the ramp distance).
module tb_ramp_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [7:0] cmd_target_i;
   logic [7:0] cmd_div_i;
   logic       abort_i;
   logic [7:0] count_o;
   logic       step_o;
   logic       up_o;
   logic       busy_o;
   logic       done_o;
   logic       aborted_o;

   int n_checks = 0;
   int n_errors = 0;
   int cmd_idx  = 0;

   logic [7:0] m_count;
   logic       m_up;

   always #5 clk_i = ~clk_i;

   ramp_sequencer #(
      .WIDTH     (8),
      .INIT      (0),
      .DIV_WIDTH (8)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_target_i (cmd_target_i),
      .cmd_div_i    (cmd_div_i),
      .abort_i      (abort_i),
      .count_o      (count_o),
      .step_o       (step_o),
      .up_o         (up_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .aborted_o    (aborted_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_outputs(input string ph, input logic [7:0] cnt, input logic stp,
                                 input logic up, input logic bsy, input logic dn,
                                 input logic ab, input logic rdy);
      chk({ph, ".count"},   32'(count_o),     32'(cnt));
      chk({ph, ".step"},    32'(step_o),      32'(stp));
      chk({ph, ".up"},      32'(up_o),        32'(up));
      chk({ph, ".busy"},    32'(busy_o),      32'(bsy));
      chk({ph, ".done"},    32'(done_o),      32'(dn));
      chk({ph, ".aborted"}, 32'(aborted_o),   32'(ab));
      chk({ph, ".ready"},   32'(cmd_ready_o), 32'(rdy));
   endtask

   // Issue one command from an idle DUT and follow it to done/aborted.
   // abort_pick: 0 none, <0 random edge, >0 that many edges after accept.
   // hold: keep valid high with (hold_tgt, div 0) for the next command.
   task automatic run_cmd(input logic [7:0] tgt, input logic [7:0] dv, input int abort_pick,
                          input bit hold, input logic [7:0] hold_tgt);
      int start, ti, d, per, fin, a_at, steps;
      bit up_dir, abt, stp;
      logic [7:0] exp_cnt;
      string ph;
      start  = int'(m_count);
      ti     = int'(tgt);
      up_dir = ti > start;
      d      = up_dir ? ti - start : start - ti;
      per    = int'(dv) + 1;
      fin    = d * per;
      a_at   = 0;
      if (d > 0 && abort_pick < 0) a_at = int'($urandom_range(1, fin));
      else if (d > 0 && abort_pick > 0 && abort_pick <= fin) a_at = abort_pick;
      abt = (a_at > 0);
      if (abt) fin = a_at;
      exp_cnt = m_count;
      chk($sformatf("cmd%0d.ready_idle", cmd_idx), 32'(cmd_ready_o), 32'd1);
      cmd_valid_i  = 1'b1;
      cmd_target_i = tgt;
      cmd_div_i    = dv;
      abort_i      = 1'b0;
      @(posedge clk_i);
      for (int t = 0; t <= fin; t++) begin
         if (t > 0) @(posedge clk_i);
         @(negedge clk_i);
         ph = $sformatf("cmd%0d_t%0d", cmd_idx, t);
         steps = (abt && t >= a_at) ? (a_at - 1) / per : t / per;
         if (steps > d) steps = d;
         exp_cnt = up_dir ? 8'(start + steps) : 8'(start - steps);
         if (d == 0) begin
            expect_outputs(ph, exp_cnt, 1'b0, m_up, 1'b0, 1'b1, 1'b0, 1'b1);
         end else begin
            stp = (t > 0) && (t % per == 0) && !(abt && t == a_at);
            expect_outputs(ph, exp_cnt, stp, up_dir, t < fin, !abt && t == fin,
                           abt && t == fin, t == fin);
         end
         if (t == 0) begin
            if (hold) begin
               cmd_target_i = hold_tgt;
               cmd_div_i    = 8'h00;
            end else begin
               cmd_valid_i  = 1'b0;
               cmd_target_i = 8'($urandom_range(0, 255));
               cmd_div_i    = 8'($urandom_range(0, 255));
            end
         end
         abort_i = abt && (t + 1 == a_at);
      end
      abort_i = 1'b0;
      m_count = exp_cnt;
      if (d > 0) m_up = up_dir;
      cmd_idx++;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_target_i = 8'h00;
      cmd_div_i    = 8'h00;
      abort_i      = 1'b0;
      repeat (2) @(negedge clk_i);
      expect_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_i   = 1'b0;
      m_count = 8'h00;
      m_up    = 1'b0;

      // up ramp 00->05 div 2; down ramp 05->02 div 0; equal target; abort on a due step
      run_cmd(8'h05, 8'd2, 0, 1'b0, 8'h00);
      run_cmd(8'h02, 8'd0, 0, 1'b0, 8'h00);
      run_cmd(8'h02, 8'd5, 0, 1'b0, 8'h00);
      run_cmd(8'h0A, 8'd3, 8, 1'b0, 8'h00);

      // reset asserted between edges in the middle of a ramp
      @(negedge clk_i);
      cmd_valid_i  = 1'b1;
      cmd_target_i = 8'h40;
      cmd_div_i    = 8'd1;
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      repeat (6) @(negedge clk_i);
      chk("midreset.count_before", 32'(count_o), 32'(8'h03 + 8'd3));
      rst_i = 1'b1;
      #1;
      expect_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk_i);
      expect_outputs("midreset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_i   = 1'b0;
      m_count = 8'h00;
      m_up    = 1'b0;
      @(negedge clk_i);

      // top endpoint: stop at FF, held command accepted only after done
      run_cmd(8'hFD, 8'd0, 0, 1'b0, 8'h00);
      run_cmd(8'hFF, 8'd0, 0, 1'b1, 8'hF0);
      run_cmd(8'hF0, 8'd0, 0, 1'b0, 8'h00);

      // bottom endpoint
      run_cmd(8'h00, 8'd0, 0, 1'b0, 8'h00);
      run_cmd(8'h03, 8'd1, 0, 1'b0, 8'h00);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] tg;
         int ab;
         if ($urandom_range(0, 3) == 0) tg = 8'($urandom_range(0, 255));
         else tg = m_count + 8'($urandom_range(0, 12)) - 8'd6;
         ab = ($urandom_range(0, 3) == 0) ? -1 : 0;
         run_cmd(tg, 8'($urandom_range(0, 3)), ab, 1'b0, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
